digtube_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment scan controller for the board's digit tubes: time-multiplexes NUM_DIGITS hex digits onto one shared segment bus, with per-digit decimal points, selectable segment polarity and tear-free frame-synchronised display updates. It sits between the CPU's memory-mapped I/O write path and the tube pins. It is the generalised successor of the fixed 8-digit driver.

---
 rtl/digtube_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_digtube_scan_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/digtube_scan_ctrl.sv
// rtl/digtube_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-synchronised updates
// Optional leading-zero blanking enabled by defining DIGTUBE_LZB_EN.
module digtube_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 20000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  output logic                    upd_pend,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   led_en,
  output logic                    led_ca,
  output logic                    led_cb,
  output logic                    led_cc,
  output logic                    led_cd,
  output logic                    led_ce,
  output logic                    led_cf,
  output logic                    led_cg,
  output logic                    led_dp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0]         CNT_TOP = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_TOP = IW'(NUM_DIGITS - 1);
  localparam logic                  SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] EN_RST  = ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1));

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic [DW-1:0]         disp_data, disp_data_nxt, pend_data;
  logic [NUM_DIGITS-1:0] disp_dp, disp_dp_nxt, pend_dp;
  logic [6:0]            seg_q;
  logic [6:0]            seg_lit;
  logic [3:0]            nib;
  logic                  tick, boundary, blank;

  // Glyph bits ordered a..g, MSB = a, 1 = lit.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1110011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b0001101;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  assign tick     = (cnt == CNT_TOP);
  assign boundary = tick && (idx == '0);

  always_comb begin
    idx_next = idx;
    if (tick) idx_next = (idx == '0) ? IDX_TOP : idx - 1'b1;
  end

  // The display register only moves at a frame boundary; a write on that
  // exact cycle bypasses the pending register and wins over it.
  always_comb begin
    disp_data_nxt = disp_data;
    disp_dp_nxt   = disp_dp;
    if (boundary && wr_en) begin
      disp_data_nxt = wr_data;
      disp_dp_nxt   = wr_dp;
    end else if (boundary && upd_pend) begin
      disp_data_nxt = pend_data;
      disp_dp_nxt   = pend_dp;
    end
  end

  assign nib = disp_data_nxt[{idx_next, 2'b00} +: 4];

`ifdef DIGTUBE_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  always_comb begin
    logic z;
    z = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (disp_data_nxt[4*i +: 4] == 4'h0);
      lead_zero[i] = z;
    end
  end
  assign blank = (idx_next != '0) && lead_zero[idx_next];
`else
  assign blank = 1'b0;
`endif

  assign seg_lit = blank ? 7'b0000000 : glyph(nib);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= IDX_TOP;
      disp_data  <= '0;
      disp_dp    <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      upd_pend   <= 1'b0;
      frame_done <= 1'b0;
      led_en     <= EN_RST;
      seg_q      <= {7{SEG_INV}};
      led_dp     <= SEG_INV;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      idx        <= idx_next;
      disp_data  <= disp_data_nxt;
      disp_dp    <= disp_dp_nxt;
      frame_done <= boundary && (wr_en || upd_pend);
      if (boundary) begin
        upd_pend <= 1'b0;
      end else if (wr_en) begin
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
        upd_pend  <= 1'b1;
      end
      // Enable, segments and dp all switch on the same edge to avoid ghosting.
      if (tick) begin
        led_en <= ~(NUM_DIGITS'(1) << idx_next);
        seg_q  <= {7{SEG_INV}} ^ seg_lit;
        led_dp <= SEG_INV ^ disp_dp_nxt[idx_next];
      end
    end
  end

  assign led_ca = seg_q[6];
  assign led_cb = seg_q[5];
  assign led_cc = seg_q[4];
  assign led_cd = seg_q[3];
  assign led_ce = seg_q[2];
  assign led_cf = seg_q[1];
  assign led_cg = seg_q[0];

endmodule

// File: tb/tb_digtube_scan_ctrl.sv
// tb/tb_digtube_scan_ctrl.sv - self-checking bench for digtube_scan_ctrl (8 digits, SCAN_DIV=4, low-active)
module tb_digtube_scan_ctrl;

  localparam int ND  = 8;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic        upd_pend, frame_done;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;

  digtube_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .upd_pend(upd_pend), .frame_done(frame_done), .led_en(led_en),
    .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
    .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int checks = 0;
  int errors = 0;

  // Reference state: time since reset release plus the values held by the display.
  int          t;
  logic [31:0] m_disp, m_pd;
  logic [7:0]  m_dp, m_pp;
  logic        m_upd, m_fd;
  logic [7:0]  e_en;
  logic [6:0]  e_seg;
  logic        e_dp;
  int          fd_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("led_en", {24'h0, led_en}, {24'h0, e_en});
    chk("segs", {25'h0, led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg}, {25'h0, e_seg});
    chk("led_dp", {31'h0, led_dp}, {31'h0, e_dp});
    chk("upd_pend", {31'h0, upd_pend}, {31'h0, m_upd});
    chk("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
  endtask

  task automatic model_reset();
    t = 0; m_disp = '0; m_pd = '0; m_dp = '0; m_pp = '0;
    m_upd = 1'b0; m_fd = 1'b0;
    e_en = 8'b0111_1111; e_seg = 7'h7f; e_dp = 1'b1;
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic [7:0] p);
    logic tk, bnd;
    int   slot_idx;
    logic [6:0] lit;
    wr_en = w; wr_data = d; wr_dp = p;
    @(posedge clk);
    tk  = (t % DIV == DIV - 1);
    bnd = tk && ((t / DIV) % ND == ND - 1);
    m_fd = bnd && (w || m_upd);
    if (bnd) begin
      if (w) begin m_disp = d; m_dp = p; end
      else if (m_upd) begin m_disp = m_pd; m_dp = m_pp; end
      m_upd = 1'b0;
    end else if (w) begin
      m_pd = d; m_pp = p; m_upd = 1'b1;
    end
    t++;
    if (tk) begin
      slot_idx = ND - 1 - ((t / DIV) % ND);
      e_en = ~(8'd1 << slot_idx);
      lit  = glyph_tab[m_disp[4*slot_idx +: 4]];
`ifdef DIGTUBE_LZB_EN
      if (slot_idx > 0 && (m_disp >> (4*slot_idx)) == 0) lit = 7'b0;
`endif
      e_seg = ~lit;
      e_dp  = ~m_dp[slot_idx];
    end
    #2;
    if (frame_done) fd_count++;
    chk_all();
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h0);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < ND * DIV && (t % (ND * DIV)) != phase; i++) step(1'b0, 32'h0, 8'h0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_dp = '0;
    fd_count = 0;
    model_reset();
    @(negedge clk); chk_all();
    @(negedge clk); chk_all();
    rst = 1'b0;

    // Blank slot after reset, then glyph 0 rotating through the digits.
    idle(40);

    // Mid-frame write shows up only after the next boundary.
    run_to(10);
    step(1'b1, 32'h0123ABCF, 8'h01);
    idle(70);

    // Two writes in one frame: last write wins, one frame_done.
    run_to(5);
    fd_count = 0;
    step(1'b1, 32'h11111111, 8'h00);
    run_to(20);
    step(1'b1, 32'h22222222, 8'hff);
    idle(64);
    chk("fd_count", fd_count, 1);

    // Write exactly on the boundary cycle bypasses the pending register.
    run_to(31);
    step(1'b1, $urandom, 8'($urandom));
    idle(40);

    // Leading-zero values (blanking when that feature is compiled in).
    run_to(12);
    step(1'b1, 32'h00000A05, 8'h10);
    idle(64);
    step(1'b1, 32'h00000000, 8'h00);
    idle(64);

    // Random writes at random times.
    for (int i = 0; i < 300; i++)
      step($urandom_range(7) == 0, $urandom, 8'($urandom));

    // Asynchronous reset mid-frame discards pending data.
    run_to(8);
    step(1'b1, 32'h89ABCDEF, 8'h5a);
    idle(3);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all();
    @(negedge clk);
    rst = 1'b0;
    idle(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
